// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler: FSM/grant
// encodings, report frame length, ASCII bytes and time-word field positions.
package uart_tx_scheduler_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, NEXT} state_t;
  typedef enum logic {ECHO, REPORT} grant_t;

  localparam int DATA_W     = 8;
  localparam int REPORT_LEN = 15;

  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_W     = 8'h57;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int HOUR_MSB = 23;
  localparam int HOUR_LSB = 19;
  localparam int MIN_MSB  = 18;
  localparam int MIN_LSB  = 13;
  localparam int SEC_MSB  = 12;
  localparam int SEC_LSB  = 7;
  localparam int CS_MSB   = 6;
  localparam int CS_LSB   = 0;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle around the scheduler: echo FIFO pop, report request/time,
// and the uart_tx start/busy pair. master = scheduler, slave = its environment.
interface uart_tx_scheduler_if;

  logic        i_echo_valid;
  logic [7:0]  i_echo_data;
  logic        o_echo_ready;
  logic        i_report_req;
  logic [23:0] i_time;
  logic        i_mode;
  logic        i_tx_busy;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;

  modport master (
    input  i_echo_valid, i_echo_data, i_report_req, i_time, i_mode, i_tx_busy,
    output o_echo_ready, o_tx_start, o_tx_data, o_busy
  );

  modport slave (
    output i_echo_valid, i_echo_data, i_report_req, i_time, i_mode, i_tx_busy,
    input  o_echo_ready, o_tx_start, o_tx_data, o_busy
  );

endinterface

// File: rtl/uart_tx_scheduler_dec2_ascii.sv
// Combinational 7-bit value to two ASCII decimal digits, saturating at "99".
module dec2_ascii
  import uart_tx_scheduler_pkg::*;
(
  input  logic [6:0] value,
  output logic [7:0] tens,
  output logic [7:0] ones
);

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  logic [6:0] sat, t, o;

  always_comb begin
    sat = sat99(value);
    t   = sat / 7'd10;
    o   = sat % 7'd10;
  end

  assign tens = ASCII_ZERO + {1'b0, t};
  assign ones = ASCII_ZERO + {1'b0, o};

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates the shared uart_tx between command echo bytes and ASCII time
// report frames; frames are atomic and priority alternates between frames.
// Optional build macro PERIODIC_REPORT_EN adds an internal periodic report request.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int BUSY_TIMEOUT  = 4,
  parameter int REPORT_PERIOD = 100_000_000
)(
  input logic clk,
  input logic rst,
  uart_tx_scheduler_if.master bus
);

  localparam int TO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  state_t            state, state_nxt;
  grant_t            last_grant, cur_grant;
  logic              report_pending, periodic_req, report_new, report_want;
  logic [3:0]        idx, len;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] tx_data, frame_byte;
  logic [23:0]       snap_time;
  logic              snap_mode;
  logic              grant_echo, grant_report, echo_ready, tx_start;
  logic              frame_last, to_expired;
  logic [7:0]        h1, h0, m1, m0, s1, s0, c1, c0;

`ifdef PERIODIC_REPORT_EN
  localparam int PER_W = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
  logic [PER_W-1:0] period_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               period_cnt <= '0;
    else if (periodic_req) period_cnt <= '0;
    else                   period_cnt <= period_cnt + 1'b1;
  end

  assign periodic_req = (period_cnt == PER_W'(REPORT_PERIOD - 1));
`else
  logic [31:0] unused_period;
  assign unused_period = 32'(REPORT_PERIOD);
  assign periodic_req  = 1'b0;
`endif

  // A request arriving in the grant cycle counts immediately, so it only
  // re-arms pending when a previously pending request is what got granted.
  assign report_new  = bus.i_report_req | periodic_req;
  assign report_want = report_pending | report_new;
  assign frame_last  = (idx == len - 4'd1);
  assign to_expired  = (to_cnt == TO_W'(BUSY_TIMEOUT - 1));

  always_comb begin
    state_nxt    = state;
    grant_echo   = 1'b0;
    grant_report = 1'b0;
    echo_ready   = 1'b0;
    tx_start     = 1'b0;
    case (state)
      IDLE: begin
        if (report_want && (!bus.i_echo_valid || last_grant == ECHO)) begin
          grant_report = 1'b1;
          state_nxt    = LOAD;
        end else if (bus.i_echo_valid) begin
          grant_echo = 1'b1;
          echo_ready = 1'b1;
          state_nxt  = SEND;
        end
      end
      LOAD: state_nxt = SEND;
      SEND: begin
        if (!bus.i_tx_busy) begin
          tx_start  = 1'b1;
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.i_tx_busy)   state_nxt = WAIT_LO;
        else if (to_expired) state_nxt = NEXT;
      end
      WAIT_LO: if (!bus.i_tx_busy) state_nxt = NEXT;
      NEXT:    state_nxt = frame_last ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      report_pending <= 1'b0;
      idx            <= '0;
      len            <= '0;
      to_cnt         <= '0;
      last_grant     <= ECHO;
      cur_grant      <= ECHO;
      tx_data        <= '0;
    end else begin
      report_pending <= grant_report ? (report_pending & report_new) : report_want;
      if (grant_echo) begin
        tx_data   <= bus.i_echo_data;
        len       <= 4'd1;
        idx       <= '0;
        cur_grant <= ECHO;
      end
      if (grant_report) begin
        len       <= 4'(REPORT_LEN);
        idx       <= '0;
        cur_grant <= REPORT;
      end
      if (state == LOAD) tx_data <= frame_byte;
      if (tx_start)               to_cnt <= '0;
      else if (state == WAIT_HI)  to_cnt <= to_cnt + 1'b1;
      if (state == NEXT) begin
        if (frame_last) last_grant <= cur_grant;
        else            idx        <= idx + 4'd1;
      end
    end
  end

  // Snapshot is data only; it is always rewritten before a frame uses it.
  always_ff @(posedge clk) begin
    if (grant_report) begin
      snap_time <= bus.i_time;
      snap_mode <= bus.i_mode;
    end
  end

  dec2_ascii u_hour (.value({2'b00, snap_time[HOUR_MSB:HOUR_LSB]}), .tens(h1), .ones(h0));
  dec2_ascii u_min  (.value({1'b0,  snap_time[MIN_MSB:MIN_LSB]}),   .tens(m1), .ones(m0));
  dec2_ascii u_sec  (.value({1'b0,  snap_time[SEC_MSB:SEC_LSB]}),   .tens(s1), .ones(s0));
  dec2_ascii u_cs   (.value(snap_time[CS_MSB:CS_LSB]),              .tens(c1), .ones(c0));

  always_comb begin
    frame_byte = ASCII_LF;
    case (idx)
      4'd0:  frame_byte = snap_mode ? ASCII_W : ASCII_S;
      4'd1:  frame_byte = ASCII_SP;
      4'd2:  frame_byte = h1;
      4'd3:  frame_byte = h0;
      4'd4:  frame_byte = ASCII_COLON;
      4'd5:  frame_byte = m1;
      4'd6:  frame_byte = m0;
      4'd7:  frame_byte = ASCII_COLON;
      4'd8:  frame_byte = s1;
      4'd9:  frame_byte = s0;
      4'd10: frame_byte = ASCII_DOT;
      4'd11: frame_byte = c1;
      4'd12: frame_byte = c0;
      4'd13: frame_byte = ASCII_CR;
      default: frame_byte = ASCII_LF;
    endcase
  end

  // Pulses are qualified with rst so every output reads 0 while reset is held.
  assign bus.o_echo_ready = echo_ready & ~rst;
  assign bus.o_tx_start   = tx_start & ~rst;
  assign bus.o_tx_data    = tx_data;
  assign bus.o_busy       = (state != IDLE);

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Sequences the shared UART transmitter between two requesters: single-byte command echo (bytes popped from the RX FIFO) and multi-byte time report frames formatted as ASCII from the displayed 24-bit time word. Sits between command_cu, the RX FIFO and uart_tx, and uses the same b_tick-driven uart_tx. Frames are atomic. Arbitration alternates priority at frame boundaries so neither requester starves.

Parameters:
BUSY_TIMEOUT, 4, cycles to wait for i_tx_busy to rise after o_tx_start before treating the byte as sent
REPORT_PERIOD, 100_000_000, clk cycles between automatic reports (used only with PERIODIC_REPORT_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
i_echo_valid  input  1  echo byte available (RX FIFO not empty)
i_echo_data  input  8  echo byte; sampled when o_echo_ready=1
o_echo_ready  output  1  1-cycle pop pulse to RX FIFO
i_report_req  input  1  1-cycle request for one time report
i_time  input  24  {hour[23:19], min[18:13], sec[12:7], cs[6:0]}
i_mode  input  1  0=stopwatch, 1=watch; selects frame prefix
i_tx_busy  input  1  uart_tx busy
o_tx_start  output  1  1-cycle start pulse to uart_tx
o_tx_data  output  8  byte to transmit; held stable from start until the byte completes
o_busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, report_pending 0, byte index 0, last_grant=ECHO (report wins the first tie). Reset mid-frame aborts immediately with no further o_tx_start. A byte already inside uart_tx completes on its own.
- report_pending is set by i_report_req in any state. It is cleared on grant. Requests while already pending merge (one-deep).
- Report frame, 15 bytes: prefix ('S' 0x53 if mode=0, 'W' 0x57 if mode=1), ' ', H1 H0 ':' M1 M0 ':' S1 S0 '.' C1 C0, 0x0D, 0x0A.
- Each field is converted to two ASCII decimal digits. Any field value >99 saturates to "99".
- States:
  - IDLE:
    - Both requesters valid: grant the one not equal to last_grant.
    - Only one requester valid: grant it.
    - Echo grant: o_echo_ready=1 for 1 cycle, latch i_echo_data into o_tx_data, set frame length 1, go to SEND.
    - Report grant: snapshot i_time and i_mode into internal registers, clear pending, set length 15 and index 0, go to LOAD.
  - LOAD: o_tx_data <= byte[index] of the snapshot frame, go to SEND.
  - SEND: when i_tx_busy=0, assert o_tx_start for exactly 1 cycle, clear the timeout counter, go to WAIT_HI.
  - WAIT_HI:
    - i_tx_busy=1: go to WAIT_LO.
    - Counter reaches BUSY_TIMEOUT: go to NEXT.
  - WAIT_LO: when i_tx_busy=0, go to NEXT.
  - NEXT:
    - If index == length-1: update last_grant, go to IDLE.
    - Else: index+1, go to LOAD.
- Inter-byte overhead: at most 3 clk cycles after uart_tx goes idle.
- The snapshot is fixed for the whole frame; i_time changes mid-frame are ignored.
- i_echo_valid is ignored outside IDLE; the FIFO buffers echo bytes meanwhile.
- i_report_req in the same cycle as a report grant is not lost: pending is re-set, giving one more frame later.

Optional Feature:
PERIODIC_REPORT_EN:
- Defined: an internal counter 0..REPORT_PERIOD-1, reset to 0, raises an internal request on wrap, ORed with i_report_req into report_pending.
- Undefined: no counter; reports come only from i_report_req. REPORT_PERIOD is unused.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, NEXT
  - grant encoding: ECHO, REPORT
  - REPORT_LEN=15
  - ASCII constants: 'S', 'W', ' ', ':', '.', CR, LF
  - time-field bit positions within the 24-bit word
- One combinational sub-module, dec2_ascii: 7-bit value in, two ASCII digit bytes out, saturating at 99. Instantiated four times.

Test Plan:
- Report, time h=12 m=34 s=56 cs=78, mode=1, uart_tx model with busy 10 cycles per byte -> start pulses carry 57 20 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A, exactly 15 pulses, then o_busy=0.
- Echo 0x72 with tx idle -> o_echo_ready 1 cycle, one o_tx_start with o_tx_data=0x72, o_busy falls after busy drops.
- Report request and echo valid in the same cycle after reset -> report frame first, then echo byte. Repeat after an echo grant -> echo first.
- Time field cs=120, mode=0 -> prefix 0x53, cs digits "99" (39 39).
- i_time changed and i_report_req re-pulsed mid-frame -> current frame keeps snapshot digits; exactly one extra frame follows with the new time.
- rst asserted after byte 5 of a frame -> no further o_tx_start, all outputs 0. Model never raising busy -> each byte advances after BUSY_TIMEOUT cycles, no lockup.
